// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if
// Bundles the hazard-detection inputs and pipeline control outputs of
// pipe_hazard_ctrl.
//   master : pipeline side, drives the ID/EX/MEM hazard fields and memory
//            handshake, receives register load/flush controls and status.
//   slave  : pipe_hazard_ctrl itself.
// Optional feature macro: PIPE_PERF_CNT_EN adds oStallCnt / oFlushCnt.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0] iRs1_id;
    logic [4:0] iRs2_id;
    logic       iUseRs1_id;
    logic       iUseRs2_id;
    logic [4:0] iWa_ex;
    logic       iMemRead_ex;
    logic       iBranchTaken_ex;
    logic       iMemReq_mem;
    logic       iMemReady;

    logic       oPCLoad;
    logic       oIFIDLoad;
    logic       oIDEXLoad;
    logic       oEXMEMLoad;
    logic       oMEMWBLoad;
    logic       oIFIDFlush;
    logic       oIDEXFlush;
    logic [2:0] oState;
    logic       oMemErr;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] oStallCnt;
    logic [CNT_W-1:0] oFlushCnt;

    modport master (
        output iRs1_id, iRs2_id, iUseRs1_id, iUseRs2_id, iWa_ex,
               iMemRead_ex, iBranchTaken_ex, iMemReq_mem, iMemReady,
        input  oPCLoad, oIFIDLoad, oIDEXLoad, oEXMEMLoad, oMEMWBLoad,
               oIFIDFlush, oIDEXFlush, oState, oMemErr, oStallCnt, oFlushCnt
    );

    modport slave (
        input  iRs1_id, iRs2_id, iUseRs1_id, iUseRs2_id, iWa_ex,
               iMemRead_ex, iBranchTaken_ex, iMemReq_mem, iMemReady,
        output oPCLoad, oIFIDLoad, oIDEXLoad, oEXMEMLoad, oMEMWBLoad,
               oIFIDFlush, oIDEXFlush, oState, oMemErr, oStallCnt, oFlushCnt
    );
`else
    modport master (
        output iRs1_id, iRs2_id, iUseRs1_id, iUseRs2_id, iWa_ex,
               iMemRead_ex, iBranchTaken_ex, iMemReq_mem, iMemReady,
        input  oPCLoad, oIFIDLoad, oIDEXLoad, oEXMEMLoad, oMEMWBLoad,
               oIFIDFlush, oIDEXFlush, oState, oMemErr
    );

    modport slave (
        input  iRs1_id, iRs2_id, iUseRs1_id, iUseRs2_id, iWa_ex,
               iMemRead_ex, iBranchTaken_ex, iMemReq_mem, iMemReady,
        output oPCLoad, oIFIDLoad, oIDEXLoad, oEXMEMLoad, oMEMWBLoad,
               oIFIDFlush, oIDEXFlush, oState, oMemErr
    );
`endif
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Central sequencer for the 5-stage pipeline: resolves data-memory wait,
// taken branch in EX and load-use hazard in ID (in that priority) into
// PC / pipeline-register load and bubble controls, and supervises the
// data-memory handshake with a sticky timeout error.
// Ports:
//   Clk    core clock, rising edge
//   Reset  synchronous, active-low
//   bus    pipe_hazard_ctrl_if.slave (hazard inputs, controls, status)
// Parameters:
//   WAIT_MAX  consecutive wait cycles tolerated before error (0 = never)
//   CNT_W     performance counter width
// Optional feature macro: PIPE_PERF_CNT_EN (stall/flush counters).
//
// state  | meaning
// ST_OK  | normal operation, cycle class from the hazard inputs
// ST_ERR | memory timeout seen, core frozen until Reset
module pipe_hazard_ctrl #(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 32
) (
    input logic               Clk,
    input logic               Reset,
    pipe_hazard_ctrl_if.slave bus
);
    localparam int WCNT_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST =
        (WAIT_MAX == 0) ? '0 : WCNT_W'(WAIT_MAX - 1);

    typedef enum logic [2:0] {
        CLS_RUN   = 3'd0,
        CLS_STALL = 3'd1,
        CLS_FLUSH = 3'd2,
        CLS_WAIT  = 3'd3,
        CLS_ERR   = 3'd4
    } cls_e;

    typedef enum logic {
        ST_OK,
        ST_ERR
    } state_e;

    state_e            state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    cls_e              cls;
    logic              luh;
    logic              mem_wait;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= ST_OK;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        wcnt_d          = '0;
        cls             = CLS_RUN;
        bus.oPCLoad     = 1'b1;
        bus.oIFIDLoad   = 1'b1;
        bus.oIDEXLoad   = 1'b1;
        bus.oEXMEMLoad  = 1'b1;
        bus.oMEMWBLoad  = 1'b1;
        bus.oIFIDFlush  = 1'b0;
        bus.oIDEXFlush  = 1'b0;

        // x0 is never a real producer, so a load to x0 cannot create a hazard
        luh = bus.iMemRead_ex && (bus.iWa_ex != 5'd0) &&
              ((bus.iUseRs1_id && (bus.iRs1_id == bus.iWa_ex)) ||
               (bus.iUseRs2_id && (bus.iRs2_id == bus.iWa_ex)));
        mem_wait = bus.iMemReq_mem && !bus.iMemReady;

        if (state_q == ST_ERR)       cls = CLS_ERR;
        else if (mem_wait)           cls = CLS_WAIT;
        else if (bus.iBranchTaken_ex) cls = CLS_FLUSH;
        else if (luh)                cls = CLS_STALL;
        else                         cls = CLS_RUN;

        if (cls == CLS_WAIT && WAIT_MAX != 0) begin
            if (wcnt_q == WCNT_LAST) state_d = ST_ERR;
            else                     wcnt_d  = wcnt_q + 1'b1;
        end

        // While Reset is low the pipeline registers load their reset
        // values, so every load stays enabled and no class is reported.
        if (Reset) begin
            unique case (cls)
                CLS_ERR, CLS_WAIT: begin
                    bus.oPCLoad    = 1'b0;
                    bus.oIFIDLoad  = 1'b0;
                    bus.oIDEXLoad  = 1'b0;
                    bus.oEXMEMLoad = 1'b0;
                    bus.oMEMWBLoad = 1'b0;
                end
                CLS_FLUSH: begin
                    bus.oIFIDFlush = 1'b1;
                    bus.oIDEXFlush = 1'b1;
                end
                CLS_STALL: begin
                    bus.oPCLoad    = 1'b0;
                    bus.oIFIDLoad  = 1'b0;
                    bus.oIDEXFlush = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.oState  = Reset ? cls : CLS_RUN;
    assign bus.oMemErr = Reset && (state_q == ST_ERR);

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    // ERR is its own class, so both counters naturally freeze there.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (cls == CLS_STALL || cls == CLS_WAIT) stall_cnt_q <= stall_cnt_q + 1'b1;
            if (cls == CLS_FLUSH)                    flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign bus.oStallCnt = stall_cnt_q;
    assign bus.oFlushCnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic
// checked against a cycle-class reference model.
module tb_pipe_hazard_ctrl;
    localparam int WAIT_MAX = 4;
    localparam int CNT_W    = 32;

    logic Clk = 1'b0;
    logic Reset = 1'b0;
    always #5 Clk = ~Clk;

    pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipe_hazard_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    bit          m_err  = 1'b0;
    int          m_wrun = 0;
    int unsigned m_stall = 0;
    int unsigned m_flush = 0;

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] wa,
                         input logic mr, input logic br, input logic mq,
                         input logic rdy, input logic rst);
        @(negedge Clk);
        bus.iRs1_id         = rs1;
        bus.iRs2_id         = rs2;
        bus.iUseRs1_id      = u1;
        bus.iUseRs2_id      = u2;
        bus.iWa_ex          = wa;
        bus.iMemRead_ex     = mr;
        bus.iBranchTaken_ex = br;
        bus.iMemReq_mem     = mq;
        bus.iMemReady       = rdy;
        Reset               = rst;
        #1;
    endtask

    function automatic logic [6:0] ctl_obs();
        return {bus.oPCLoad, bus.oIFIDLoad, bus.oIDEXLoad, bus.oEXMEMLoad,
                bus.oMEMWBLoad, bus.oIFIDFlush, bus.oIDEXFlush};
    endfunction

    // Expected cycle class from the currently driven inputs and model error.
    function automatic int exp_cls();
        bit hz;
        if (!Reset) return 0;
        if (m_err) return 4;
        hz = bus.iMemRead_ex && bus.iWa_ex != 0 &&
             ((bus.iUseRs1_id && bus.iRs1_id == bus.iWa_ex) ||
              (bus.iUseRs2_id && bus.iRs2_id == bus.iWa_ex));
        if (bus.iMemReq_mem && !bus.iMemReady) return 3;
        if (bus.iBranchTaken_ex) return 2;
        if (hz) return 1;
        return 0;
    endfunction

    function automatic logic [6:0] exp_ctl(input int c);
        case (c)
            0:       return 7'b1111100;
            1:       return 7'b0011101;
            2:       return 7'b1111111;
            default: return 7'b0000000;
        endcase
    endfunction

    // Advance one clock and update the model with the class of the cycle.
    task automatic tick();
        int c;
        c = exp_cls();
        @(posedge Clk);
        if (!Reset) begin
            m_err = 0; m_wrun = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (c == 3) begin
                m_wrun++;
                if (WAIT_MAX != 0 && m_wrun >= WAIT_MAX) m_err = 1;
            end else begin
                m_wrun = 0;
            end
            if (c == 1 || c == 3) m_stall++;
            if (c == 2) m_flush++;
        end
    endtask

    task automatic test_reset();
        drive(5, 2, 1, 1, 5, 1, 1, 1, 0, 0);
        n_checks++;
        if (bus.oState !== 3'd0 || ctl_obs() !== 7'b1111100 || bus.oMemErr !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: state=%0d ctl=%b err=%b, expected state=0 ctl=1111100 err=0",
                     bus.oState, ctl_obs(), bus.oMemErr);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        n_checks++;
        if (bus.oState !== 3'd0 || ctl_obs() !== 7'b1111100 || bus.oMemErr !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: state=%0d ctl=%b err=%b, expected state=0 ctl=1111100 err=0",
                     bus.oState, ctl_obs(), bus.oMemErr);
        end
`ifdef PIPE_PERF_CNT_EN
        n_checks++;
        if (bus.oStallCnt !== '0 || bus.oFlushCnt !== '0) begin
            n_fail++;
            $display("FAIL reset_counters: stall=%0d flush=%0d, expected 0 0", bus.oStallCnt, bus.oFlushCnt);
        end
`endif
        tick();
    endtask

    task automatic test_load_use();
        int unsigned s0;
        s0 = m_stall;
        drive(5, 2, 1, 1, 5, 1, 0, 0, 1, 1);
        n_checks++;
        if (bus.oState !== 3'd1 || ctl_obs() !== 7'b0011101) begin
            n_fail++;
            $display("FAIL load_use_rs1: state=%0d ctl=%b, expected state=1 ctl=0011101", bus.oState, ctl_obs());
        end
        tick();
        drive(5, 2, 1, 1, 0, 0, 0, 0, 1, 1);
        n_checks++;
        if (bus.oState !== 3'd0 || ctl_obs() !== 7'b1111100) begin
            n_fail++;
            $display("FAIL load_use_after: state=%0d ctl=%b, expected state=0 ctl=1111100", bus.oState, ctl_obs());
        end
`ifdef PIPE_PERF_CNT_EN
        n_checks++;
        if (bus.oStallCnt !== CNT_W'(s0 + 1)) begin
            n_fail++;
            $display("FAIL load_use_cnt: stall=%0d, expected %0d", bus.oStallCnt, s0 + 1);
        end
`endif
        tick();
        drive(0, 2, 1, 1, 0, 1, 0, 0, 1, 1);
        n_checks++;
        if (bus.oState !== 3'd0 || ctl_obs() !== 7'b1111100) begin
            n_fail++;
            $display("FAIL load_use_x0: state=%0d ctl=%b, expected state=0 ctl=1111100", bus.oState, ctl_obs());
        end
        tick();
        drive(1, 7, 1, 1, 7, 1, 0, 0, 1, 1);
        n_checks++;
        if (bus.oState !== 3'd1 || ctl_obs() !== 7'b0011101) begin
            n_fail++;
            $display("FAIL load_use_rs2: state=%0d ctl=%b, expected state=1 ctl=0011101", bus.oState, ctl_obs());
        end
        tick();
        drive(1, 7, 1, 0, 7, 1, 0, 0, 1, 1);
        n_checks++;
        if (bus.oState !== 3'd0 || ctl_obs() !== 7'b1111100) begin
            n_fail++;
            $display("FAIL load_use_unused_rs2: state=%0d ctl=%b, expected state=0 ctl=1111100", bus.oState, ctl_obs());
        end
        tick();
    endtask

    task automatic test_branch_luh();
        int unsigned s0, f0;
        s0 = m_stall; f0 = m_flush;
        drive(5, 2, 1, 1, 5, 1, 1, 0, 1, 1);
        n_checks++;
        if (bus.oState !== 3'd2 || ctl_obs() !== 7'b1111111) begin
            n_fail++;
            $display("FAIL branch_luh: state=%0d ctl=%b, expected state=2 ctl=1111111", bus.oState, ctl_obs());
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
`ifdef PIPE_PERF_CNT_EN
        n_checks++;
        if (bus.oStallCnt !== CNT_W'(s0) || bus.oFlushCnt !== CNT_W'(f0 + 1)) begin
            n_fail++;
            $display("FAIL branch_luh_cnt: stall=%0d flush=%0d, expected %0d %0d",
                     bus.oStallCnt, bus.oFlushCnt, s0, f0 + 1);
        end
`endif
        tick();
    endtask

    task automatic test_wait_branch();
        int unsigned s0, f0;
        s0 = m_stall; f0 = m_flush;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 1, 1, 0, 1);
            n_checks++;
            if (bus.oState !== 3'd3 || ctl_obs() !== 7'b0000000 || bus.oMemErr !== 1'b0) begin
                n_fail++;
                $display("FAIL wait_branch_wait%0d: state=%0d ctl=%b err=%b, expected state=3 ctl=0000000 err=0",
                         i, bus.oState, ctl_obs(), bus.oMemErr);
            end
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 1, 1, 1, 1);
        n_checks++;
        if (bus.oState !== 3'd2 || ctl_obs() !== 7'b1111111) begin
            n_fail++;
            $display("FAIL wait_branch_flush: state=%0d ctl=%b, expected state=2 ctl=1111111", bus.oState, ctl_obs());
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
`ifdef PIPE_PERF_CNT_EN
        n_checks++;
        if (bus.oStallCnt !== CNT_W'(s0 + 3) || bus.oFlushCnt !== CNT_W'(f0 + 1)) begin
            n_fail++;
            $display("FAIL wait_branch_cnt: stall=%0d flush=%0d, expected %0d %0d",
                     bus.oStallCnt, bus.oFlushCnt, s0 + 3, f0 + 1);
        end
`endif
        tick();
    endtask

    task automatic test_timeout();
        int unsigned s0, f0;
        for (int i = 0; i < WAIT_MAX - 1; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        n_checks++;
        if (bus.oState !== 3'd0 || bus.oMemErr !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_edge_ready: state=%0d err=%b, expected state=0 err=0", bus.oState, bus.oMemErr);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        n_checks++;
        if (bus.oMemErr !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_no_err: err=%b, expected 0", bus.oMemErr);
        end
        tick();
        for (int i = 0; i < WAIT_MAX; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
            n_checks++;
            if (bus.oState !== 3'd3 || bus.oMemErr !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_wait%0d: state=%0d err=%b, expected state=3 err=0",
                         i, bus.oState, bus.oMemErr);
            end
            tick();
        end
        s0 = m_stall; f0 = m_flush;
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        n_checks++;
        if (bus.oState !== 3'd4 || bus.oMemErr !== 1'b1 || ctl_obs() !== 7'b0000000) begin
            n_fail++;
            $display("FAIL timeout_err: state=%0d err=%b ctl=%b, expected state=4 err=1 ctl=0000000",
                     bus.oState, bus.oMemErr, ctl_obs());
        end
        tick();
        drive(5, 2, 1, 1, 5, 1, 1, 1, 1, 1);
        n_checks++;
        if (bus.oState !== 3'd4 || bus.oMemErr !== 1'b1 || ctl_obs() !== 7'b0000000) begin
            n_fail++;
            $display("FAIL timeout_sticky: state=%0d err=%b ctl=%b, expected state=4 err=1 ctl=0000000",
                     bus.oState, bus.oMemErr, ctl_obs());
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 0, 1, 1);
`ifdef PIPE_PERF_CNT_EN
        n_checks++;
        if (bus.oStallCnt !== CNT_W'(s0) || bus.oFlushCnt !== CNT_W'(f0)) begin
            n_fail++;
            $display("FAIL timeout_cnt_frozen: stall=%0d flush=%0d, expected %0d %0d",
                     bus.oStallCnt, bus.oFlushCnt, s0, f0);
        end
`endif
        tick();
    endtask

    task automatic test_reset_mid_wait();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        n_checks++;
        if (bus.oState !== 3'd0 || ctl_obs() !== 7'b1111100 || bus.oMemErr !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_err_hold: state=%0d ctl=%b err=%b, expected state=0 ctl=1111100 err=0",
                     bus.oState, ctl_obs(), bus.oMemErr);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        n_checks++;
        if (bus.oState !== 3'd0 || ctl_obs() !== 7'b1111100 || bus.oMemErr !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_err_release: state=%0d ctl=%b err=%b, expected state=0 ctl=1111100 err=0",
                     bus.oState, ctl_obs(), bus.oMemErr);
        end
`ifdef PIPE_PERF_CNT_EN
        n_checks++;
        if (bus.oStallCnt !== '0 || bus.oFlushCnt !== '0) begin
            n_fail++;
            $display("FAIL rst_err_cnt: stall=%0d flush=%0d, expected 0 0", bus.oStallCnt, bus.oFlushCnt);
        end
`endif
        tick();
        // partial wait, reset, then a full tolerated run must not time out
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        tick();
        for (int i = 0; i < WAIT_MAX - 1; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
            n_checks++;
            if (bus.oState !== 3'd3 || bus.oMemErr !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_mid_wait%0d: state=%0d err=%b, expected state=3 err=0",
                         i, bus.oState, bus.oMemErr);
            end
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        tick();
    endtask

    task automatic test_random();
        int c;
        for (int i = 0; i < 600; i++) begin
            drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
                  1'($urandom), ($urandom_range(0, 3) == 0),
                  1'($urandom), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 39) != 0));
            c = exp_cls();
            n_checks++;
            if (bus.oState !== 3'(c) || ctl_obs() !== exp_ctl(c) || bus.oMemErr !== (Reset && m_err)) begin
                n_fail++;
                $display("FAIL random_%0d: state=%0d ctl=%b err=%b, expected state=%0d ctl=%b err=%b",
                         i, bus.oState, ctl_obs(), bus.oMemErr, c, exp_ctl(c), Reset && m_err);
            end
`ifdef PIPE_PERF_CNT_EN
            n_checks++;
            if (bus.oStallCnt !== CNT_W'(m_stall) || bus.oFlushCnt !== CNT_W'(m_flush)) begin
                n_fail++;
                $display("FAIL random_cnt_%0d: stall=%0d flush=%0d, expected %0d %0d",
                         i, bus.oStallCnt, bus.oFlushCnt, m_stall, m_flush);
            end
`endif
            tick();
        end
    endtask

    initial begin
        bus.iRs1_id = '0; bus.iRs2_id = '0; bus.iUseRs1_id = 1'b0; bus.iUseRs2_id = 1'b0;
        bus.iWa_ex = '0; bus.iMemRead_ex = 1'b0; bus.iBranchTaken_ex = 1'b0;
        bus.iMemReq_mem = 1'b0; bus.iMemReady = 1'b1;
        test_reset();
        test_load_use();
        test_branch_luh();
        test_wait_branch();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
